mv_collector: RTL
=================

Name: mv_collector

Overview:
- Sits directly downstream of the ME core and consumes its per-macroblock result strobe: MSAD, MSAD_row, MSAD_column, data_valid.
- Converts each raw search-window position into a signed motion vector and tags it with the macroblock coordinate.
- Buffers results in a small FIFO toward the bitstream/MV writer using a valid/ready handshake.
- Accumulates the per-frame SAD total and pulses a frame-done flag after the last macroblock of a frame.

Parameters:
- SEARCH_OFF, 16, window offset subtracted from row/column to give a signed MV (range -16..+15)
- MB_COLS, 11, macroblocks per row (QCIF 176/16)
- MB_ROWS, 9, macroblock rows per frame (QCIF 144/16)
- FIFO_DEPTH, 8, result FIFO entries (power of two)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- data_valid  in  1  one-cycle strobe from ME: result fields valid this cycle
- MSAD  in  14  minimum SAD of the current macroblock
- MSAD_row  in  5  row index of best match in the search window (0..31)
- MSAD_column  in  5  column index of best match (0..31)
- clr_ovf  in  1  synchronous clear of the sticky overflow flag
- mv_valid  out  1  FIFO head valid
- mv_ready  in  1  consumer accepts the head this cycle
- mv_x  out  6  signed MV x = MSAD_column - SEARCH_OFF
- mv_y  out  6  signed MV y = MSAD_row - SEARCH_OFF
- mv_sad  out  14  SAD of the head entry
- mb_x  out  5  macroblock column of the head entry
- mb_y  out  5  macroblock row of the head entry
- fifo_count  out  4  current occupancy (0..FIFO_DEPTH)
- overflow  out  1  sticky: a result arrived while the FIFO was full
- frame_done  out  1  one-cycle pulse after the last macroblock of a frame is captured
- frame_sad  out  24  frame SAD total, held stable from the frame_done pulse until the next frame_done

Behaviour:
- Reset (rst=0, asynchronous) forces the following; the FIFO pointers and contents are don't-care after reset.
  - Outputs to 0: mv_valid, mv_x, mv_y, mv_sad, mb_x, mb_y, fifo_count, overflow, frame_done, frame_sad.
  - The mb_x/mb_y capture counters and the SAD accumulator to 0.
- Capture (data_valid=1):
  - mv_x/mv_y are computed as 6-bit two's complement of the zero-extended index minus SEARCH_OFF. Example: column 0 -> -16 (6'h30); column 31 -> +15.
  - The entry {mv_x, mv_y, MSAD, cap_mb_x, cap_mb_y} is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle (mv_valid & mv_ready).
  - Otherwise the entry is dropped and overflow is set to 1. overflow holds until clr_ovf=1; set has priority over a simultaneous clr_ovf.
- Capture counters advance on every data_valid, including dropped ones, so coordinates stay aligned with the ME scan order.
  - cap_mb_x increments and wraps MB_COLS-1 -> 0; on that wrap cap_mb_y increments and wraps MB_ROWS-1 -> 0.
- SAD accumulator: acc += MSAD on every data_valid, including drops. Width 24 bits, no saturation needed (99 x 16383 < 2^21).
  - On the capture of (MB_COLS-1, MB_ROWS-1), the next cycle has frame_done=1 and frame_sad = acc + that MSAD, and acc clears to 0.
  - The first data_valid after that starts a new frame at (0,0).
- FIFO:
  - Synchronous, registered outputs. An entry pushed into an empty FIFO appears with mv_valid=1 on the next cycle (latency 1, no combinational bypass).
  - Pop occurs when mv_valid & mv_ready.
  - The head fields must stay stable while mv_valid=1 and mv_ready=0.
  - fifo_count reflects push/pop after each edge; simultaneous push and pop leave the count unchanged.
  - The pointers are log2(FIFO_DEPTH)-bit and wrap naturally.
- Back-to-back data_valid on consecutive cycles must be accepted. The ME core never does this today, but the block must not depend on spacing.
- There is no per-frame reset input; the frame boundary is purely count-based.

Decomposition:
- Shared package me_pkg holds:
  - the SAD_W=14, IDX_W=5 and MV_W=6 width constants;
  - the mv_entry_t struct {mv_x, mv_y, sad, mb_x, mb_y};
  - a sign_offset() function implementing index - SEARCH_OFF.
- One sub-module, mv_fifo: a generic sync FIFO parameterised on width and depth, with push/pop/full/empty/count. mv_collector instantiates it with an mv_entry_t payload.

Test Plan:
- Reset then a single data_valid with MSAD=100, row=16, col=16 and mv_ready=1 -> next cycle mv_valid=1, mv_x=0, mv_y=0, mv_sad=100, mb_x=0, mb_y=0; the following cycle mv_valid=0.
- Signed conversion: inputs with row=0, col=31 -> mv_y=-16 (6'h30), mv_x=+15 (6'h0F).
- Backpressure with mv_ready=0 and 9 strobes -> fifo_count=8, overflow=1, the 9th result is lost. Then mv_ready=1 -> 8 entries drain in order with mb_x 0..7; clr_ovf clears overflow.
- Full FIFO with data_valid and mv_ready both high in the same cycle -> push accepted, count stays 8, overflow stays 0.
- 99 strobes each with MSAD=10 -> frame_done pulses exactly once, the cycle after the 99th strobe, with frame_sad=990. The 100th strobe is tagged mb_x=0, mb_y=0; mb_y reaches 8 at the 89th entry.
- Assert rst=0 mid-frame with 3 entries queued -> fifo_count, mv_valid and frame_sad go to 0 immediately. The next strobe is tagged (0,0) and the accumulator restarts.

Source files
------------

// File: rtl/me_pkg.sv
// me_pkg: shared widths, the motion-vector result record and the
// window-index to signed-MV conversion used by the ME result path.
package me_pkg;

    localparam int unsigned SAD_W = 14;  // SAD of one 16x16 macroblock
    localparam int unsigned IDX_W = 5;   // search-window index / MB coordinate
    localparam int unsigned MV_W  = 6;   // signed motion vector component

    // One buffered result as seen by the MV writer.
    typedef struct packed {
        logic [MV_W-1:0]  mv_x;
        logic [MV_W-1:0]  mv_y;
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] mb_x;
        logic [IDX_W-1:0] mb_y;
    } mv_entry_t;

    // Window index minus the window offset, as MV_W-bit two's complement.
    function automatic logic [MV_W-1:0] sign_offset(input logic [IDX_W-1:0] idx,
                                                    input int unsigned      off);
        logic [MV_W-1:0] off_w;
        off_w = MV_W'(off);
        return {1'b0, idx} - off_w;
    endfunction

endpackage

// File: rtl/mv_fifo.sv
// mv_fifo: generic synchronous FIFO with registered storage.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push / din   : write request and payload (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   dout         : head entry, driven straight from the storage flops
//   full, empty  : occupancy flags
//   count        : occupancy 0..DEPTH
// DEPTH must be a power of two; pointers wrap naturally.
module mv_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop & (count_q != '0);
        // When full, the slot being vacated by a same-cycle pop is the one
        // wr_ptr points at, so the write can reuse it.
        do_push = push & ((count_q != FULL_CNT) | do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mv_collector.sv
// mv_collector: turns the ME core's per-macroblock result strobe into
// signed motion vectors tagged with the macroblock coordinate, buffers
// them toward the MV writer, and totals the SAD per frame.
//   clk, rst                  : clock, asynchronous active-low reset
//   data_valid, MSAD,
//   MSAD_row, MSAD_column     : ME result strobe and fields
//   clr_ovf                   : clears the sticky overflow flag
//   mv_valid / mv_ready       : head-of-FIFO handshake
//   mv_x, mv_y, mv_sad,
//   mb_x, mb_y                : head entry fields
//   fifo_count                : FIFO occupancy
//   overflow                  : sticky, a result was dropped on a full FIFO
//   frame_done, frame_sad     : end-of-frame pulse and the held frame total
module mv_collector
    import me_pkg::*;
#(
    parameter int unsigned SEARCH_OFF = 16,
    parameter int unsigned MB_COLS    = 11,
    parameter int unsigned MB_ROWS    = 9,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_valid,
    input  logic [SAD_W-1:0]              MSAD,
    input  logic [IDX_W-1:0]              MSAD_row,
    input  logic [IDX_W-1:0]              MSAD_column,
    input  logic                          clr_ovf,
    output logic                          mv_valid,
    input  logic                          mv_ready,
    output logic [MV_W-1:0]               mv_x,
    output logic [MV_W-1:0]               mv_y,
    output logic [SAD_W-1:0]              mv_sad,
    output logic [IDX_W-1:0]              mb_x,
    output logic [IDX_W-1:0]              mb_y,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [23:0]                   frame_sad
);

    localparam logic [IDX_W-1:0] LAST_X = IDX_W'(MB_COLS - 1);
    localparam logic [IDX_W-1:0] LAST_Y = IDX_W'(MB_ROWS - 1);

    logic [IDX_W-1:0] cap_x_q, cap_x_d;
    logic [IDX_W-1:0] cap_y_q, cap_y_d;
    logic [23:0]      acc_q, acc_d;
    logic [23:0]      frame_sad_q, frame_sad_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    logic             fifo_full, fifo_empty;
    logic             pop, push, accept;
    logic [23:0]      sum;
    mv_entry_t        entry, head;

    assign pop    = ~fifo_empty & mv_ready;
    // A full FIFO still takes the new result if the head leaves this cycle.
    assign accept = ~fifo_full | pop;
    assign push   = data_valid & accept;

    always_comb begin
        entry.mv_x = sign_offset(MSAD_column, SEARCH_OFF);
        entry.mv_y = sign_offset(MSAD_row, SEARCH_OFF);
        entry.sad  = MSAD;
        entry.mb_x = cap_x_q;
        entry.mb_y = cap_y_q;
    end

    always_comb begin
        cap_x_d      = cap_x_q;
        cap_y_d      = cap_y_q;
        acc_d        = acc_q;
        frame_sad_d  = frame_sad_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        sum          = acc_q + 24'(MSAD);

        // Coordinates and the SAD total advance on every strobe, dropped or
        // not, so they stay locked to the ME scan order.
        if (data_valid) begin
            acc_d = sum;
            if (cap_x_q == LAST_X) begin
                cap_x_d = '0;
                if (cap_y_q == LAST_Y) begin
                    cap_y_d      = '0;
                    frame_done_d = 1'b1;
                    frame_sad_d  = sum;
                    acc_d        = '0;
                end else begin
                    cap_y_d = cap_y_q + 1'b1;
                end
            end else begin
                cap_x_d = cap_x_q + 1'b1;
            end
        end

        // Setting wins over a simultaneous clear.
        if (data_valid & ~accept) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_x_q      <= '0;
            cap_y_q      <= '0;
            acc_q        <= '0;
            frame_sad_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cap_x_q      <= cap_x_d;
            cap_y_q      <= cap_y_d;
            acc_q        <= acc_d;
            frame_sad_q  <= frame_sad_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    mv_fifo #(
        .WIDTH ($bits(mv_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign mv_valid   = ~fifo_empty;
    assign mv_x       = head.mv_x;
    assign mv_y       = head.mv_y;
    assign mv_sad     = head.sad;
    assign mb_x       = head.mb_x;
    assign mb_y       = head.mb_y;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign frame_sad  = frame_sad_q;

endmodule
